// File: rtl/dp_pkg.sv
// Shared definitions for the dot-product accelerator: engine state encoding
// and default datapath widths used by the AXI master and result register.
package dp_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } dp_state_e;

  localparam int unsigned DP_DATA_W = 8;
  localparam int unsigned DP_ACC_W  = 32;
  localparam int unsigned DP_LEN_W  = 16;

endpackage

// File: rtl/dp_mac_pipe.sv
// Two-stage MAC datapath: registered product, then a modulo accumulator whose
// carry-out sets a sticky overflow flag until the next job clear.
module dp_mac_pipe #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ACC_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              load,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  acc,
  output logic              ovf
);

  logic [2*DATA_W-1:0] prod_q;
  logic                prod_vld_q;
  logic [ACC_W-1:0]    acc_q;
  logic                ovf_q;
  logic [ACC_W-1:0]    prod_ext;
  logic [ACC_W:0]      sum;

  always_comb begin
    prod_ext                 = '0;
    prod_ext[2*DATA_W-1:0]   = prod_q;
    sum                      = {1'b0, acc_q} + {1'b0, prod_ext};
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      prod_q     <= '0;
      prod_vld_q <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      prod_vld_q <= load;
      if (load)
        prod_q <= {{DATA_W{1'b0}}, a} * {{DATA_W{1'b0}}, b};
      if (prod_vld_q) begin
        acc_q <= sum[ACC_W-1:0];
        if (sum[ACC_W])
          ovf_q <= 1'b1;
      end
    end
  end

  assign acc = acc_q;
  assign ovf = ovf_q;

endmodule

// File: rtl/dp_mac_engine.sv
// Streaming dot-product engine: job FSM, element counter and the operand /
// result handshakes around the dp_mac_pipe datapath.
module dp_mac_engine
  import dp_pkg::*;
#(
  parameter int unsigned DATA_W = DP_DATA_W,
  parameter int unsigned ACC_W  = DP_ACC_W,
  parameter int unsigned LEN_W  = DP_LEN_W
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              start,
  input  logic [LEN_W-1:0]  vec_len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [ACC_W-1:0]  res_data,
  output logic              ovf,
  output logic              busy,
  output logic [DATA_W-1:0] dp_a,
  output logic [DATA_W-1:0] dp_b
);

  dp_state_e         state_q, state_d;
  logic [LEN_W-1:0]  remaining_q;
  logic              drain_q;
  logic [ACC_W-1:0]  res_data_q;
  logic [DATA_W-1:0] dp_a_q, dp_b_q;
  logic              job_clear;
  logic              accept;
  logic [ACC_W-1:0]  acc;

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    res_valid = 1'b0;
    job_clear = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          job_clear = 1'b1;
          state_d   = (vec_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        in_ready = 1'b1;
        if (in_valid && remaining_q == LEN_W'(1))
          state_d = DRAIN;
      end
      DRAIN: begin
        if (drain_q)
          state_d = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign accept = in_valid && in_ready;

  // DRAIN spans two edges so the final product has reached acc before capture
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      drain_q     <= 1'b0;
      res_data_q  <= '0;
      dp_a_q      <= '0;
      dp_b_q      <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= (state_q == DRAIN) && !drain_q;
      if (job_clear) begin
        remaining_q <= vec_len;
        res_data_q  <= '0;
      end
      if (accept) begin
        remaining_q <= remaining_q - LEN_W'(1);
        dp_a_q      <= in_a;
        dp_b_q      <= in_b;
      end
      if (state_q == DRAIN && drain_q)
        res_data_q <= acc;
    end
  end

  dp_mac_pipe #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_pipe (
    .clk   (ACLK),
    .rst   (ARESET),
    .clear (job_clear),
    .load  (accept),
    .a     (in_a),
    .b     (in_b),
    .acc   (acc),
    .ovf   (ovf)
  );

  assign res_data = res_data_q;
  assign busy     = (state_q != IDLE);
  assign dp_a     = dp_a_q;
  assign dp_b     = dp_b_q;

endmodule

// File: tb/tb_dp_mac_engine.sv
// Scoreboard bench for dp_mac_engine: a 32-bit and a 17-bit accumulator
// instance share stimulus; expected sums are modelled per accumulator width.
module tb_dp_mac_engine;

  logic        clk = 1'b0;
  logic        areset;
  logic        start;
  logic [15:0] vec_len;
  logic        in_valid;
  logic        in_ready, r17_in_ready;
  logic [7:0]  in_a, in_b;
  logic        res_valid, r17_valid;
  logic        res_ready;
  logic [31:0] res_data;
  logic [16:0] r17_data;
  logic        ovf, r17_ovf;
  logic        busy, r17_busy;
  logic [7:0]  dp_a, dp_b, r17_dp_a, r17_dp_b;

  typedef struct {
    logic [31:0] d32;
    logic        o32;
    logic [16:0] d17;
    logic        o17;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  va[8];
  logic [7:0]  vb[8];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  dp_mac_engine dut (
    .ACLK(clk), .ARESET(areset), .start(start), .vec_len(vec_len),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .ovf(ovf), .busy(busy), .dp_a(dp_a), .dp_b(dp_b)
  );

  dp_mac_engine #(.DATA_W(8), .ACC_W(17), .LEN_W(16)) dut17 (
    .ACLK(clk), .ARESET(areset), .start(start), .vec_len(vec_len),
    .in_valid(in_valid), .in_ready(r17_in_ready), .in_a(in_a), .in_b(in_b),
    .res_valid(r17_valid), .res_ready(res_ready), .res_data(r17_data),
    .ovf(r17_ovf), .busy(r17_busy), .dp_a(r17_dp_a), .dp_b(r17_dp_b)
  );

  task automatic start_job(input logic [15:0] len);
    exp_t e;
    start = 1'b1; vec_len = len;
    @(posedge clk); #1;
    start = 1'b0;
    n_checks++;
    if (busy !== 1'b1 || r17_busy !== 1'b1) begin
      n_fail++; $display("FAIL start_busy: busy=%b/%b required 1", busy, r17_busy);
    end
    n_checks++;
    if (in_ready !== (len != 0)) begin
      n_fail++; $display("FAIL start_in_ready: got %b required %b", in_ready, len != 0);
    end
    if (len == 0) begin
      e.d32 = '0; e.o32 = 1'b0; e.d17 = '0; e.o17 = 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic feed(input int unsigned total, input int unsigned stop_at,
                      input bit bubbles, input bit mid_start);
    int unsigned     i = 0;
    int unsigned     guard = 0;
    bit              hs;
    bit              gap = 1'b0;
    bit              pulsed = 1'b0;
    longint unsigned sum = 0;
    exp_t            e;
    while (i < stop_at && guard < 200) begin
      in_valid = !(bubbles && gap);
      in_a = va[i]; in_b = vb[i];
      if (mid_start && i == 1 && !pulsed) begin
        start = 1'b1; vec_len = 16'd1; pulsed = 1'b1;
      end
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      start = 1'b0;
      guard++;
      if (hs) begin
        sum += longint'(va[i]) * longint'(vb[i]);
        i++;
      end
      gap = !gap;
    end
    in_valid = 1'b0;
    n_checks++;
    if (i != stop_at) begin
      n_fail++; $display("FAIL feed_timeout: accepted %0d required %0d", i, stop_at);
    end
    if (stop_at == total) begin
      e.d32 = sum[31:0];
      e.o32 = (sum >= 64'h1_0000_0000);
      e.d17 = sum[16:0];
      e.o17 = (sum >= 64'h2_0000);
      sb.push_back(e);
    end
  endtask

  task automatic wait_result(input string name);
    exp_t        e;
    int unsigned cyc = 0;
    while (!res_valid && cyc < 64) begin
      @(posedge clk); #1; cyc++;
    end
    n_checks++;
    if (res_valid !== 1'b1 || r17_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s_valid: res_valid=%b/%b required 1", name, res_valid, r17_valid);
    end
    n_checks++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL %s_sb: scoreboard empty, required 1 entry", name);
    end else begin
      e = sb.pop_front();
      n_checks++;
      if (res_data !== e.d32) begin
        n_fail++; $display("FAIL %s_data32: got %0h required %0h", name, res_data, e.d32);
      end
      n_checks++;
      if (ovf !== e.o32) begin
        n_fail++; $display("FAIL %s_ovf32: got %b required %b", name, ovf, e.o32);
      end
      n_checks++;
      if (r17_data !== e.d17) begin
        n_fail++; $display("FAIL %s_data17: got %0h required %0h", name, r17_data, e.d17);
      end
      n_checks++;
      if (r17_ovf !== e.o17) begin
        n_fail++; $display("FAIL %s_ovf17: got %b required %b", name, r17_ovf, e.o17);
      end
    end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b0;
    n_checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_release: res_valid=%b busy=%b required 0 0", name, res_valid, busy);
    end
  endtask

  task automatic check_reset_vals(input string name);
    n_checks++;
    if ({in_ready, res_valid, ovf, busy} !== 4'b0 || res_data !== '0 ||
        dp_a !== '0 || dp_b !== '0 || r17_data !== '0 || r17_ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: rdy=%b vld=%b ovf=%b busy=%b data=%0h a=%0h b=%0h d17=%0h required all 0",
               name, in_ready, res_valid, ovf, busy, res_data, dp_a, dp_b, r17_data);
    end
  endtask

  task automatic test_reset();
    areset = 1'b1; start = 1'b0; vec_len = '0; in_valid = 1'b0;
    in_a = '0; in_b = '0; res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("reset_values");
    areset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    va[0] = 1; va[1] = 2; va[2] = 3; vb[0] = 4; vb[1] = 5; vb[2] = 6;
    start_job(16'd3);
    feed(3, 3, 1'b0, 1'b0);
    n_checks++;
    if (in_ready !== 1'b0 || res_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_k0: rdy=%b vld=%b required 0 0", in_ready, res_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (res_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_k1: res_valid=%b required 0", res_valid);
    end
    @(posedge clk); #1;
    n_checks++;
    if (res_valid !== 1'b1) begin
      n_fail++; $display("FAIL basic_k2: res_valid=%b required 1", res_valid);
    end
    wait_result("basic");
  endtask

  task automatic test_bubbles();
    start_job(16'd3);
    feed(3, 3, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (dp_a !== 8'd3 || dp_b !== 8'd6) begin
      n_fail++; $display("FAIL bubbles_dp: a=%0d b=%0d required 3 6", dp_a, dp_b);
    end
    wait_result("bubbles");
  endtask

  task automatic test_overflow();
    for (int unsigned i = 0; i < 3; i++) begin
      va[i] = 8'hFF; vb[i] = 8'hFF;
    end
    start_job(16'd3);
    feed(3, 3, 1'b0, 1'b0);
    wait_result("overflow");
  endtask

  task automatic test_zero_len();
    start_job(16'd0);
    in_valid = 1'b1; in_a = 8'h11; in_b = 8'h22;
    for (int unsigned c = 0; c < 5; c++) begin
      if (c == 2) begin
        start = 1'b1; vec_len = 16'd5;
      end
      n_checks++;
      if (res_valid !== 1'b1 || res_data !== '0 || ovf !== 1'b0) begin
        n_fail++; $display("FAIL zero_hold%0d: vld=%b data=%0h ovf=%b required 1 0 0",
                           c, res_valid, res_data, ovf);
      end
      @(posedge clk); #1;
      start = 1'b0;
    end
    in_valid = 1'b0;
    n_checks++;
    if (dp_a !== 8'hFF || dp_b !== 8'hFF) begin
      n_fail++; $display("FAIL zero_no_consume: a=%0h b=%0h required ff ff", dp_a, dp_b);
    end
    wait_result("zero_len");
    @(posedge clk); #1;
    n_checks++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL zero_ignored_start: busy=%b required 0", busy);
    end
  endtask

  task automatic test_reset_mid();
    va[0] = 1; va[1] = 2; va[2] = 3; va[3] = 4;
    vb[0] = 5; vb[1] = 6; vb[2] = 7; vb[3] = 8;
    start_job(16'd4);
    feed(4, 2, 1'b0, 1'b0);
    areset = 1'b1; in_valid = 1'b1; start = 1'b1; vec_len = 16'd2;
    @(posedge clk); #1;
    check_reset_vals("reset_mid");
    areset = 1'b0; in_valid = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    va[0] = 7; vb[0] = 9;
    start_job(16'd1);
    feed(1, 1, 1'b0, 1'b0);
    wait_result("after_reset");
  endtask

  task automatic test_mid_start();
    va[0] = 10; va[1] = 20; va[2] = 30; vb[0] = 3; vb[1] = 4; vb[2] = 5;
    start_job(16'd3);
    feed(3, 3, 1'b0, 1'b1);
    wait_result("mid_start");
  endtask

  task automatic test_back_to_back();
    va[0] = 2; va[1] = 3; vb[0] = 5; vb[1] = 7;
    start_job(16'd2);
    feed(2, 2, 1'b0, 1'b0);
    wait_result("b2b_first");
    va[0] = 100; va[1] = 200; vb[0] = 200; vb[1] = 250;
    start_job(16'd2);
    feed(2, 2, 1'b0, 1'b0);
    wait_result("b2b_second");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bubbles();
    test_overflow();
    test_zero_len();
    test_reset_mid();
    test_mid_start();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
